// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-port RAM with combinational read.
// One access per three cycles: IDLE samples requests, SERVE drives the RAM, ACK returns data.
module mem_arbiter #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic              a_ack_o,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              b_ack_o,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic              mem_load_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_in_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    ACK   = 2'd2
  } state_e;

  localparam logic FIXED_EN = (FIXED_PRIO != 0);

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  // State, grant and read-data registers; last resets to B so A wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // Next-state: arbitrate in IDLE, capture the RAM word at the end of SERVE.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      IDLE: begin
        if (a_req_i && b_req_i) begin
          sel_d   = FIXED_EN ? 1'b0 : ~last_q;
          state_d = SERVE;
        end else if (a_req_i) begin
          sel_d   = 1'b0;
          state_d = SERVE;
        end else if (b_req_i) begin
          sel_d   = 1'b1;
          state_d = SERVE;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE: begin
        // Read data is the pre-write word even for a write access.
        if (sel_q) begin
          b_rdata_d = mem_rdata_i;
        end else begin
          a_rdata_d = mem_rdata_i;
        end
        last_d  = sel_q;
        state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state/sel only, so reset kills mem_load at once.
  always_comb begin
    mem_load_o = 1'b0;
    mem_addr_o = '0;
    mem_in_o   = '0;
    a_ack_o    = 1'b0;
    b_ack_o    = 1'b0;
    busy_o     = (state_q != IDLE);
    case (state_q)
      SERVE: begin
        if (sel_q) begin
          mem_load_o = b_we_i;
          mem_addr_o = b_addr_i;
          mem_in_o   = b_wdata_i;
        end else begin
          mem_load_o = a_we_i;
          mem_addr_o = a_addr_i;
          mem_in_o   = a_wdata_i;
        end
      end
      ACK: begin
        a_ack_o = ~sel_q;
        b_ack_o = sel_q;
      end
      default: begin
        mem_load_o = 1'b0;
      end
    endcase
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule
